// File: rtl/mul_err_profiler.sv
// mul_err_profiler: sweeps every operand pair into an external approximate
// multiplier, compares against the exact product and accumulates error stats.
module mul_err_profiler #(
    parameter int unsigned W     = 8,
    parameter int unsigned LAT   = 0,
    parameter int unsigned ACC_W = 4*W+2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    signed_mode,
    output logic [W-1:0]            op_a,
    output logic [W-1:0]            op_b,
    input  logic [2*W-1:0]          approx_p,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    output logic signed [ACC_W-1:0] err_sum,
    output logic [ACC_W-1:0]        abs_err_sum,
    output logic [2*W:0]            max_abs_err,
    output logic [2*W:0]            err_count,
    output logic signed [2*W:0]     comp_const
);
    localparam int unsigned PW = 2*W;   // product width
    localparam int unsigned EW = 2*W+1; // error width

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           pair_q, pair_d;      // {op_a, op_b}
    logic                    mode_q, mode_d;
    logic                    res_valid_q, res_valid_d;
    logic                    flush, clear_acc, issue_valid;

    logic signed [PW-1:0]    prod_s;
    logic [PW-1:0]           prod_u;
    logic [EW-1:0]           exact_x, approx_x;
    logic                    pipe_valid, dly_empty;
    logic [EW-1:0]           pipe_exact;

    logic                    err_valid_q, err_valid_d;
    logic signed [EW-1:0]    err_q, err_d;
    logic [EW-1:0]           abs_err;

    logic signed [ACC_W-1:0] err_sum_q, err_sum_d;
    logic [ACC_W-1:0]        abs_sum_q, abs_sum_d;
    logic [EW-1:0]           max_q, max_d;
    logic [EW-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0] rounded;

    // Exact reference product of the pair currently on the operand bus
    assign prod_s  = PW'($signed(pair_q[PW-1:W])) * PW'($signed(pair_q[W-1:0]));
    assign prod_u  = PW'(pair_q[PW-1:W]) * PW'(pair_q[W-1:0]);
    assign exact_x = mode_q ? {prod_s[PW-1], prod_s} : {1'b0, prod_u};
    assign approx_x = mode_q ? {approx_p[PW-1], approx_p} : {1'b0, approx_p};
    assign issue_valid = (state_q == ST_RUN);

    // Delay the exact product so it lines up with the multiplier's output
    generate
        if (LAT == 0) begin : g_nodly
            assign pipe_valid = issue_valid;
            assign pipe_exact = exact_x;
            assign dly_empty  = 1'b1;
        end else begin : g_dly
            logic [LAT-1:0]         dv_q, dv_d;
            logic [LAT-1:0][EW-1:0] dx_q, dx_d;

            // Shift register next-state; abort drops everything in flight
            always_comb begin
                dv_d    = dv_q;
                dx_d    = dx_q;
                dv_d[0] = issue_valid;
                dx_d[0] = exact_x;
                for (int unsigned i = 1; i < LAT; i++) begin
                    dv_d[i] = dv_q[i-1];
                    dx_d[i] = dx_q[i-1];
                end
                if (flush) dv_d = '0;
            end

            // Delay line registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dv_q <= '0;
                    dx_q <= '0;
                end else begin
                    dv_q <= dv_d;
                    dx_q <= dx_d;
                end
            end

            assign pipe_valid = dv_q[LAT-1];
            assign pipe_exact = dx_q[LAT-1];
            assign dly_empty  = ~|dv_q;
        end
    endgenerate

    assign abs_err = err_q[EW-1] ? $unsigned(-err_q) : $unsigned(err_q);

    // Sweep FSM, error register and accumulator next-state
    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        mode_d      = mode_q;
        res_valid_d = res_valid_q;
        flush       = 1'b0;
        clear_acc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    clear_acc   = 1'b1;
                    mode_d      = signed_mode;
                    pair_d      = '0;
                    res_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else begin
                    pair_d = pair_q + PW'(1);
                    if (pair_q == '1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else if (!err_valid_q && dly_empty) begin
                    state_d     = ST_DONE;
                    res_valid_d = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        err_valid_d = pipe_valid && !flush;
        err_d       = approx_x - pipe_exact;

        err_sum_d = err_sum_q;
        abs_sum_d = abs_sum_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        if (clear_acc) begin
            err_sum_d = '0;
            abs_sum_d = '0;
            max_d     = '0;
            cnt_d     = '0;
        end else if (err_valid_q) begin
            err_sum_d = err_sum_q + ACC_W'(err_q);
            abs_sum_d = abs_sum_q + ACC_W'(abs_err);
            max_d     = (abs_err > max_q) ? abs_err : max_q;
            if (err_q != '0) cnt_d = cnt_q + EW'(1);
        end
    end

    // State, operand counter, error register and accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pair_q      <= '0;
            mode_q      <= 1'b0;
            res_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_q       <= '0;
            err_sum_q   <= '0;
            abs_sum_q   <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            mode_q      <= mode_d;
            res_valid_q <= res_valid_d;
            err_valid_q <= err_valid_d;
            err_q       <= err_d;
            err_sum_q   <= err_sum_d;
            abs_sum_q   <= abs_sum_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
        end
    end

    // Round-to-nearest mean error over 2^(2W) samples
    assign rounded    = err_sum_q + (ACC_W'(1) << (PW - 1));
    assign comp_const = EW'(rounded >>> PW);

    assign op_a        = pair_q[PW-1:W];
    assign op_b        = pair_q[W-1:0];
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign res_valid   = res_valid_q;
    assign err_sum     = err_sum_q;
    assign abs_err_sum = abs_sum_q;
    assign max_abs_err = max_q;
    assign err_count   = cnt_q;

endmodule

// File: tb/tb_mul_err_profiler.sv
// Bench for mul_err_profiler: two instances (LAT=0 and LAT=2) share the
// control inputs, each fed by its own behavioural multiplier model.
module tb_mul_err_profiler;
    localparam int W     = 4;
    localparam int ACC_W = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, signed_mode;
    int         em;
    logic [7:0] rand_tab [256];

    logic [3:0]  op_a0, op_b0, op_a2, op_b2;
    logic [7:0]  apx0, apx2, p2_s1;
    logic        busy0, done0, rv0, busy2, done2, rv2;
    logic signed [17:0] es0, es2;
    logic [17:0] as0, as2;
    logic [8:0]  mx0, mx2, ct0, ct2;
    logic signed [8:0] cc0, cc2;

    int total = 0;
    int bad   = 0;
    int e_sum, e_abs, e_max, e_cnt, e_comp;

    typedef struct {
        logic busy; logic done; logic rv;
        logic [3:0] oa; logic [3:0] ob;
        logic [17:0] es; logic [17:0] abs_s;
        logic [8:0] mx; logic [8:0] ct; logic [8:0] cc;
    } snap_t;

    // Multiplier under test: em 0 exact, 1 exact+1, 2 bit0 cleared, 3 table
    function automatic logic [7:0] model(input logic sm, input int emode,
                                         input logic [3:0] a, input logic [3:0] b,
                                         input logic [7:0] rnd);
        int va, vb, p;
        logic [7:0] pb;
        va = (sm && a[3]) ? int'(a) - 16 : int'(a);
        vb = (sm && b[3]) ? int'(b) - 16 : int'(b);
        p  = va * vb;
        if (emode == 1) p = p + 1;
        pb = p[7:0];
        if (emode == 2) pb[0] = 1'b0;
        if (emode == 3) pb = rnd;
        return pb;
    endfunction

    assign apx0 = model(signed_mode, em, op_a0, op_b0, rand_tab[{op_a0, op_b0}]);

    always @(posedge clk) begin
        p2_s1 <= model(signed_mode, em, op_a2, op_b2, rand_tab[{op_a2, op_b2}]);
        apx2  <= p2_s1;
    end

    mul_err_profiler #(.W(W), .LAT(0), .ACC_W(ACC_W)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .signed_mode(signed_mode), .op_a(op_a0), .op_b(op_b0), .approx_p(apx0),
        .busy(busy0), .done(done0), .res_valid(rv0), .err_sum(es0),
        .abs_err_sum(as0), .max_abs_err(mx0), .err_count(ct0), .comp_const(cc0)
    );

    mul_err_profiler #(.W(W), .LAT(2), .ACC_W(ACC_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .signed_mode(signed_mode), .op_a(op_a2), .op_b(op_b2), .approx_p(apx2),
        .busy(busy2), .done(done2), .res_valid(rv2), .err_sum(es2),
        .abs_err_sum(as2), .max_abs_err(mx2), .err_count(ct2), .comp_const(cc2)
    );

    function automatic snap_t snap(input int inst);
        snap_t s;
        if (inst == 0) begin
            s.busy = busy0; s.done = done0; s.rv = rv0; s.oa = op_a0; s.ob = op_b0;
            s.es = es0; s.abs_s = as0; s.mx = mx0; s.ct = ct0; s.cc = cc0;
        end else begin
            s.busy = busy2; s.done = done2; s.rv = rv2; s.oa = op_a2; s.ob = op_b2;
            s.es = es2; s.abs_s = as2; s.mx = mx2; s.ct = ct2; s.cc = cc2;
        end
        return s;
    endfunction

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 0 : 2;
    endfunction

    // Reference: plain integer statistics over every operand pair
    task automatic ref_model(input logic sm, input int emode);
        int va, vb, ex, ap, er, ae, x;
        logic [7:0] bits;
        e_sum = 0; e_abs = 0; e_max = 0; e_cnt = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                va   = (sm && a >= 8) ? a - 16 : a;
                vb   = (sm && b >= 8) ? b - 16 : b;
                ex   = va * vb;
                bits = model(sm, emode, a[3:0], b[3:0], rand_tab[a*16 + b]);
                ap   = (sm && bits >= 8'd128) ? int'(bits) - 256 : int'(bits);
                er   = ap - ex;
                ae   = (er < 0) ? -er : er;
                e_sum += er;
                e_abs += ae;
                if (ae > e_max) e_max = ae;
                if (er != 0) e_cnt++;
            end
        end
        x = e_sum + 128;
        e_comp = (x >= 0) ? x / 256 : -((-x + 255) / 256);
    endtask

    task automatic run_sweep(input string name, input logic sm, input int emode, input bit poke);
        int c;
        int done_at [2];
        int done_n [2];
        int busy_bad [2];
        int rv_bad [2];
        int op_bad;
        snap_t s;
        logic exp_busy;
        ref_model(sm, emode);
        done_at = '{-1, -1}; done_n = '{0, 0}; busy_bad = '{0, 0}; rv_bad = '{0, 0};
        op_bad = 0;
        @(negedge clk);
        signed_mode = sm; em = emode; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c <= 300) begin
            for (int i = 0; i < 2; i++) begin
                s = snap(i);
                exp_busy = (c < 258 + lat_of(i));
                if (s.busy !== exp_busy) busy_bad[i]++;
                if (s.done === 1'b1) begin
                    if (done_at[i] < 0) done_at[i] = c;
                    done_n[i]++;
                    if (s.rv !== 1'b1) rv_bad[i]++;
                end
                if (c < 256 && (s.oa !== c[7:4] || s.ob !== c[3:0])) op_bad++;
            end
            if (poke) start = (c == 49);
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (op_bad !== 0) begin
            bad++; $display("FAIL %s op_order mismatches=%0d exp=0", name, op_bad);
        end
        for (int i = 0; i < 2; i++) begin
            s = snap(i);
            total++;
            if (done_at[i] !== 258 + lat_of(i)) begin
                bad++; $display("FAIL %s L%0d done_latency got=%0d exp=%0d", name, lat_of(i), done_at[i], 258 + lat_of(i));
            end
            total++;
            if (done_n[i] !== 1) begin
                bad++; $display("FAIL %s L%0d done_width got=%0d exp=1", name, lat_of(i), done_n[i]);
            end
            total++;
            if (busy_bad[i] !== 0) begin
                bad++; $display("FAIL %s L%0d busy_window mismatches=%0d exp=0", name, lat_of(i), busy_bad[i]);
            end
            total++;
            if (rv_bad[i] !== 0 || s.rv !== 1'b1) begin
                bad++; $display("FAIL %s L%0d res_valid got=%b exp=1", name, lat_of(i), s.rv);
            end
            total++;
            if (s.es !== 18'(e_sum)) begin
                bad++; $display("FAIL %s L%0d err_sum got=%0d exp=%0d", name, lat_of(i), $signed(s.es), e_sum);
            end
            total++;
            if (s.abs_s !== 18'(e_abs)) begin
                bad++; $display("FAIL %s L%0d abs_err_sum got=%0d exp=%0d", name, lat_of(i), s.abs_s, e_abs);
            end
            total++;
            if (s.mx !== 9'(e_max)) begin
                bad++; $display("FAIL %s L%0d max_abs_err got=%0d exp=%0d", name, lat_of(i), s.mx, e_max);
            end
            total++;
            if (s.ct !== 9'(e_cnt)) begin
                bad++; $display("FAIL %s L%0d err_count got=%0d exp=%0d", name, lat_of(i), s.ct, e_cnt);
            end
            total++;
            if (s.cc !== 9'(e_comp)) begin
                bad++; $display("FAIL %s L%0d comp_const got=%0d exp=%0d", name, lat_of(i), $signed(s.cc), e_comp);
            end
        end
    endtask

    task automatic test_reset;
        snap_t s;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; signed_mode = 1'b0; em = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s = snap(i);
            total++;
            if ({s.busy, s.done, s.rv} !== 3'b000) begin
                bad++; $display("FAIL reset L%0d flags got=%b%b%b exp=000", lat_of(i), s.busy, s.done, s.rv);
            end
            total++;
            if ({s.oa, s.ob} !== 8'h00) begin
                bad++; $display("FAIL reset L%0d ops got=%h exp=00", lat_of(i), {s.oa, s.ob});
            end
            total++;
            if (s.es !== '0 || s.abs_s !== '0 || s.mx !== '0 || s.ct !== '0 || s.cc !== '0) begin
                bad++; $display("FAIL reset L%0d accum got=%0d/%0d/%0d/%0d/%0d exp=0", lat_of(i), s.es, s.abs_s, s.mx, s.ct, s.cc);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exact;
        run_sweep("exact_signed", 1'b1, 0, 1'b0);
    endtask

    task automatic test_plus_one;
        run_sweep("plus_one_signed_poke", 1'b1, 1, 1'b1);
    endtask

    task automatic test_unsigned_lsb;
        run_sweep("lsb_clear_unsigned", 1'b0, 2, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 256; i++) rand_tab[i] = 8'($urandom);
        run_sweep("random_signed", 1'b1, 3, 1'b0);
        for (int i = 0; i < 256; i++) rand_tab[i] = 8'($urandom);
        run_sweep("random_unsigned", 1'b0, 3, 1'b0);
    endtask

    task automatic test_abort;
        int c;
        int seen_done, seen_busy;
        snap_t s;
        @(negedge clk);
        signed_mode = 1'b1; em = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < 99) begin
            @(posedge clk); c++; @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s = snap(i);
            total++;
            if (s.busy !== 1'b0 || s.done !== 1'b0) begin
                bad++; $display("FAIL abort L%0d busy_done got=%b%b exp=00", lat_of(i), s.busy, s.done);
            end
        end
        seen_done = 0; seen_busy = 0;
        repeat (300) begin
            @(negedge clk);
            if (done0 !== 1'b0 || done2 !== 1'b0) seen_done++;
            if (busy0 !== 1'b0 || busy2 !== 1'b0) seen_busy++;
        end
        total++;
        if (seen_done !== 0 || seen_busy !== 0) begin
            bad++; $display("FAIL abort quiet done_cycles=%0d busy_cycles=%0d exp=0/0", seen_done, seen_busy);
        end
        total++;
        if (rv0 !== 1'b0 || rv2 !== 1'b0) begin
            bad++; $display("FAIL abort res_valid got=%b%b exp=00", rv0, rv2);
        end
        run_sweep("after_abort", 1'b1, 1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int seen;
        snap_t s;
        @(negedge clk);
        signed_mode = 1'b1; em = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (120) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            s = snap(i);
            total++;
            if ({s.busy, s.done, s.rv} !== 3'b000 || {s.oa, s.ob} !== 8'h00) begin
                bad++; $display("FAIL rst_mid L%0d ctrl got=%b%b%b ops=%h exp=000/00", lat_of(i), s.busy, s.done, s.rv, {s.oa, s.ob});
            end
            total++;
            if (s.es !== '0 || s.abs_s !== '0 || s.mx !== '0 || s.ct !== '0 || s.cc !== '0) begin
                bad++; $display("FAIL rst_mid L%0d accum got=%0d/%0d/%0d/%0d/%0d exp=0", lat_of(i), s.es, s.abs_s, s.mx, s.ct, s.cc);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy0 || busy2 || done0 || done2 || {op_a0, op_b0, op_a2, op_b2} !== 16'h0000) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rst_mid idle_after_release active_cycles=%0d exp=0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rand_tab[i] = 8'h00;
        test_reset();
        test_exact();
        test_plus_one();
        test_unsigned_lsb();
        test_random();
        test_abort();
        test_reset_mid();
        run_sweep("after_reset", 1'b1, 1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
